stream_from_memory_multi: RTL

Parametrised successor to the single-region memory streamer used in front of the UART and Ethernet TX drivers. On a start pulse it streams one of N_REGIONS preprogrammed address windows out of an external synchronous RAM/ROM, one word per downstream request. A prefetch FIFO hides RAM read latency and absorbs variable latency. It reports busy/done, and can optionally loop a region a programmable number of times.

---
 rtl/stream_from_memory_multi.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/stream_from_memory_multi.sv
// stream_from_memory_multi: streams one of N_REGIONS address windows out of an
// external synchronous RAM, one word per downstream request. A small prefetch
// FIFO hides RAM latency. A start while busy aborts and restarts; RAM returns
// still in flight for the aborted stream are counted out and dropped.
// Build option: define STREAM_MEM_LOOP_EN to stream the region loops_i+1 times.
module stream_from_memory_multi #(
   parameter int DATA_W     = 8,
   parameter int ADDR_W     = 10,
   parameter int N_REGIONS  = 4,
   parameter int SEL_W      = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int LOOP_W     = 8
) (
   input  logic                        clk_i,
   input  logic                        rstn_i,
   input  logic                        start_i,
   input  logic [SEL_W-1:0]            sel_i,
   input  logic [N_REGIONS*ADDR_W-1:0] read_start_i,
   input  logic [N_REGIONS*ADDR_W-1:0] read_end_i,
   input  logic [LOOP_W-1:0]           loops_i,
   input  logic                        readclk_i,
   output logic                        ram_readclk_o,
   output logic [ADDR_W-1:0]           ram_raddr_o,
   input  logic                        ram_outclk_i,
   input  logic [DATA_W-1:0]           ram_out_i,
   output logic                        outclk_o,
   output logic [DATA_W-1:0]           out_o,
   output logic                        busy_o,
   output logic                        done_o
);

   // state   | meaning
   // S_IDLE  | waiting for start; FIFO empty, no credits
   // S_FETCH | issuing RAM reads for the region (and further passes)
   // S_DRAIN | all reads issued; emitting what is left, done on last word

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int SUM_W = CNT_W + 2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_DRAIN
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W-1:0]   remain_q, remain_d;
   logic [CNT_W-1:0]    credits_q, credits_d;
   logic [CNT_W-1:0]    inflight_q, inflight_d;
   logic [CNT_W-1:0]    discard_q, discard_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0]   out_q, out_d;
   logic                outclk_q, outclk_d;
   logic                done_q, done_d;
   logic                rd_q, rd_d;
   logic [ADDR_W-1:0]   raddr_q, raddr_d;
   logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];

`ifdef STREAM_MEM_LOOP_EN
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [ADDR_W-1:0]   len_q, len_d;
   logic [LOOP_W-1:0]   loops_left_q, loops_left_d;
`else
   logic                unused_loops;
   assign unused_loops = ^loops_i;
`endif

   logic [ADDR_W-1:0]   new_start, new_end, new_len;
   logic                active, credit_in, push_v, drop, emit, last, issue;
   logic [SUM_W-1:0]    occupancy;

   // Region mux; any select without a matching region falls back to region 0.
   always_comb begin
      new_start = read_start_i[ADDR_W-1:0];
      new_end   = read_end_i[ADDR_W-1:0];
      for (int i = 1; i < N_REGIONS; i++) begin
         if (sel_i == SEL_W'(i)) begin
            new_start = read_start_i[i*ADDR_W +: ADDR_W];
            new_end   = read_end_i[i*ADDR_W +: ADDR_W];
         end
      end
   end

   assign new_len   = new_end - new_start;
   assign active    = (state_q != S_IDLE);
   assign credit_in = readclk_i && active;
   // Returns owed to an aborted stream are dropped before anything is pushed.
   assign drop      = ram_outclk_i && (discard_q != '0);
   assign push_v    = ram_outclk_i && (discard_q == '0) && (inflight_q != '0);
   assign emit      = active && !start_i && (count_q != '0)
                      && ((credits_q != '0) || credit_in);
   assign last      = emit && (state_q == S_DRAIN) && (inflight_q == '0)
                      && (count_q == CNT_W'(1));
   assign occupancy = SUM_W'(inflight_q) + SUM_W'(discard_q) + SUM_W'(count_q);
   assign issue     = (state_q == S_FETCH) && !start_i
                      && (occupancy < SUM_W'(FIFO_DEPTH));

   // Next-state logic: counters, FIFO pointers, output strobes and FSM.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      remain_d   = remain_q;
      credits_d  = credits_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      out_d      = out_q;
      outclk_d   = 1'b0;
      done_d     = 1'b0;
      rd_d       = 1'b0;
      raddr_d    = raddr_q;
`ifdef STREAM_MEM_LOOP_EN
      base_d       = base_q;
      len_d        = len_q;
      loops_left_d = loops_left_q;
`endif
      inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(push_v);
      discard_d  = discard_q - CNT_W'(drop);
      count_d    = count_q + CNT_W'(push_v) - CNT_W'(emit);

      if (push_v) wr_ptr_d = wr_ptr_q + PTR_W'(1);

      if (emit) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
         outclk_d = 1'b1;
         out_d    = mem_q[rd_ptr_q];
         done_d   = last;
      end

      // A request arriving with an emit in the same cycle is consumed directly.
      if (credit_in && !emit && (credits_q != CNT_W'(FIFO_DEPTH)))
         credits_d = credits_q + CNT_W'(1);
      else if (emit && !credit_in)
         credits_d = credits_q - CNT_W'(1);

      if (issue) begin
         rd_d    = 1'b1;
         raddr_d = addr_q;
      end

      case (state_q)
         S_FETCH: begin
            if (issue) begin
               addr_d   = addr_q + ADDR_W'(1);
               remain_d = remain_q - ADDR_W'(1);
               if (remain_q == ADDR_W'(1)) begin
`ifdef STREAM_MEM_LOOP_EN
                  if (loops_left_q != '0) begin
                     addr_d       = base_q;
                     remain_d     = len_q;
                     loops_left_d = loops_left_q - LOOP_W'(1);
                  end else begin
                     state_d = S_DRAIN;
                  end
`else
                  state_d = S_DRAIN;
`endif
               end
            end
         end
         S_DRAIN: begin
            // Linger one cycle after done so busy overlaps the final word.
            if (done_q) begin
               state_d   = S_IDLE;
               credits_d = '0;
            end
         end
         default: ;
      endcase

      if (start_i) begin
         count_d    = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         inflight_d = '0;
         discard_d  = discard_q - CNT_W'(drop) + inflight_q - CNT_W'(push_v);
         if (new_len == '0) begin
            state_d   = S_IDLE;
            credits_d = '0;
            done_d    = 1'b1;
         end else begin
            state_d   = S_FETCH;
            addr_d    = new_start;
            remain_d  = new_len;
            credits_d = CNT_W'(1);
`ifdef STREAM_MEM_LOOP_EN
            base_d       = new_start;
            len_d        = new_len;
            loops_left_d = loops_i;
`endif
         end
      end
   end

   // State and counter registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         remain_q   <= '0;
         credits_q  <= '0;
         inflight_q <= '0;
         discard_q  <= '0;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         out_q      <= '0;
         outclk_q   <= 1'b0;
         done_q     <= 1'b0;
         rd_q       <= 1'b0;
         raddr_q    <= '0;
`ifdef STREAM_MEM_LOOP_EN
         base_q       <= '0;
         len_q        <= '0;
         loops_left_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         remain_q   <= remain_d;
         credits_q  <= credits_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         out_q      <= out_d;
         outclk_q   <= outclk_d;
         done_q     <= done_d;
         rd_q       <= rd_d;
         raddr_q    <= raddr_d;
`ifdef STREAM_MEM_LOOP_EN
         base_q       <= base_d;
         len_q        <= len_d;
         loops_left_q <= loops_left_d;
`endif
      end
   end

   // FIFO storage; occupancy lives in count_q so the array needs no reset.
   always_ff @(posedge clk_i) begin
      if (push_v) mem_q[wr_ptr_q] <= ram_out_i;
   end

   assign ram_readclk_o = rd_q;
   assign ram_raddr_o   = raddr_q;
   assign outclk_o      = outclk_q;
   assign out_o         = out_q;
   assign busy_o        = active;
   assign done_o        = done_q;

endmodule
